// File: rtl/ip_lpm_tcam.sv
// Longest-prefix-match lookup over a register-based ternary route table.
// Three-cycle fully pipelined lookup path, register read/write port and hit/miss counters.
module ip_lpm_tcam #(
   parameter int DATA_WIDTH     = 64,
   parameter int NUM_QUEUES     = 8,
   parameter int LUT_DEPTH      = 32,
   parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_WIDTH-1:0]     in_data,
   input  logic                      word_IP_SRC_DST,
   input  logic                      word_IP_DST_LO,
   output logic [31:0]               next_hop_ip,
   output logic [NUM_QUEUES-1:0]     lpm_output_port,
   output logic                      lpm_vld,
   output logic                      lpm_hit,
   input  logic [LUT_DEPTH_BITS-1:0] lpm_rd_addr,
   input  logic                      lpm_rd_req,
   output logic [31:0]               lpm_rd_ip,
   output logic [31:0]               lpm_rd_mask,
   output logic [NUM_QUEUES-1:0]     lpm_rd_oq,
   output logic [31:0]               lpm_rd_next_hop_ip,
   output logic                      lpm_rd_ack,
   input  logic [LUT_DEPTH_BITS-1:0] lpm_wr_addr,
   input  logic                      lpm_wr_req,
   input  logic [31:0]               lpm_wr_ip,
   input  logic [31:0]               lpm_wr_mask,
   input  logic [NUM_QUEUES-1:0]     lpm_wr_oq,
   input  logic [31:0]               lpm_wr_next_hop_ip,
   output logic                      lpm_wr_ack,
   input  logic                      lpm_cnt_clr,
   output logic [CNT_WIDTH-1:0]      lpm_hit_cnt,
   output logic [CNT_WIDTH-1:0]      lpm_miss_cnt
);

   typedef struct packed {
      logic [31:0]           ip;
      logic [31:0]           mask;
      logic [NUM_QUEUES-1:0] oq;
      logic [31:0]           nh;
   } entry_t;

   entry_t tbl [LUT_DEPTH];

   logic            wr_in_range, rd_in_range;
   entry_t          rd_e;
   logic [15:0]     dst_hi, dst_lo;
   logic [31:0]     s2_dst;
   logic [2:1]      vld_pipe;
   logic [LUT_DEPTH-1:0]      match;
   logic                      win_hit;
   logic [LUT_DEPTH_BITS-1:0] win_idx;
   entry_t                    win_e;

   assign wr_in_range = int'(lpm_wr_addr) < LUT_DEPTH;
   assign rd_in_range = int'(lpm_rd_addr) < LUT_DEPTH;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LUT_DEPTH; i++) tbl[i] <= '0;
         lpm_wr_ack <= 1'b0;
      end else begin
         if (lpm_wr_req && wr_in_range)
            tbl[lpm_wr_addr] <= '{ip: lpm_wr_ip, mask: lpm_wr_mask,
                                  oq: lpm_wr_oq, nh: lpm_wr_next_hop_ip};
         lpm_wr_ack <= lpm_wr_req;
      end
   end

   // Read samples the table before any same-edge write lands, so a colliding read sees old data.
   always_comb begin
      rd_e = '0;
      if (rd_in_range) rd_e = tbl[lpm_rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lpm_rd_ip          <= '0;
         lpm_rd_mask        <= '0;
         lpm_rd_oq          <= '0;
         lpm_rd_next_hop_ip <= '0;
         lpm_rd_ack         <= 1'b0;
      end else begin
         lpm_rd_ack <= lpm_rd_req;
         if (lpm_rd_req) begin
            lpm_rd_ip          <= rd_e.ip;
            lpm_rd_mask        <= rd_e.mask;
            lpm_rd_oq          <= rd_e.oq;
            lpm_rd_next_hop_ip <= rd_e.nh;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dst_hi   <= '0;
         dst_lo   <= '0;
         s2_dst   <= '0;
         vld_pipe <= '0;
      end else begin
         if (word_IP_SRC_DST) dst_hi <= in_data[15:0];
         if (word_IP_DST_LO)  dst_lo <= in_data[DATA_WIDTH-1 -: 16];
         s2_dst   <= {dst_hi, dst_lo};
         vld_pipe <= {vld_pipe[1], word_IP_DST_LO};
      end
   end

   // Matching runs in the second stage so a write issued one cycle after the lookup is already visible.
   for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_match
      assign match[g] = (tbl[g].oq != '0) && (((s2_dst ^ tbl[g].ip) & tbl[g].mask) == 32'd0);
   end

   always_comb begin
      win_hit = 1'b0;
      win_idx = '0;
      for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
         if (match[i]) begin
            win_hit = 1'b1;
            win_idx = LUT_DEPTH_BITS'(i);
         end
      end
      win_e = tbl[win_idx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lpm_vld         <= 1'b0;
         lpm_hit         <= 1'b0;
         lpm_output_port <= '0;
         next_hop_ip     <= '0;
      end else begin
         lpm_vld <= vld_pipe[2];
         if (vld_pipe[2]) begin
            lpm_hit         <= win_hit;
            lpm_output_port <= win_hit ? win_e.oq : '0;
            next_hop_ip     <= (win_hit && win_e.nh != 32'd0) ? win_e.nh : s2_dst;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || lpm_cnt_clr) begin
         lpm_hit_cnt  <= '0;
         lpm_miss_cnt <= '0;
      end else if (lpm_vld) begin
         if (lpm_hit && !(&lpm_hit_cnt))    lpm_hit_cnt  <= lpm_hit_cnt + 1'b1;
         if (!lpm_hit && !(&lpm_miss_cnt))  lpm_miss_cnt <= lpm_miss_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ip_lpm_tcam.sv
// Self-checking bench for ip_lpm_tcam: directed scenarios plus a random pipelined run
// compared against a first-match-by-index route table model.
module tb_ip_lpm_tcam;
   localparam int DW = 64, NQ = 8, LD = 8, LB = 3, CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] in_data;
   logic          word_IP_SRC_DST, word_IP_DST_LO;
   logic [31:0]   next_hop_ip;
   logic [NQ-1:0] lpm_output_port;
   logic          lpm_vld, lpm_hit;
   logic [LB-1:0] lpm_rd_addr;
   logic          lpm_rd_req;
   logic [31:0]   lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip;
   logic [NQ-1:0] lpm_rd_oq;
   logic          lpm_rd_ack;
   logic [LB-1:0] lpm_wr_addr;
   logic          lpm_wr_req;
   logic [31:0]   lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip;
   logic [NQ-1:0] lpm_wr_oq;
   logic          lpm_wr_ack;
   logic          lpm_cnt_clr;
   logic [CW-1:0] lpm_hit_cnt, lpm_miss_cnt;

   int total = 0, bad = 0;

   logic [31:0]   m_ip [LD], m_mask [LD], m_nh [LD];
   logic [NQ-1:0] m_oq [LD];

   ip_lpm_tcam #(.DATA_WIDTH(DW), .NUM_QUEUES(NQ), .LUT_DEPTH(LD), .LUT_DEPTH_BITS(LB), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .in_data(in_data),
      .word_IP_SRC_DST(word_IP_SRC_DST), .word_IP_DST_LO(word_IP_DST_LO),
      .next_hop_ip(next_hop_ip), .lpm_output_port(lpm_output_port),
      .lpm_vld(lpm_vld), .lpm_hit(lpm_hit),
      .lpm_rd_addr(lpm_rd_addr), .lpm_rd_req(lpm_rd_req), .lpm_rd_ip(lpm_rd_ip),
      .lpm_rd_mask(lpm_rd_mask), .lpm_rd_oq(lpm_rd_oq),
      .lpm_rd_next_hop_ip(lpm_rd_next_hop_ip), .lpm_rd_ack(lpm_rd_ack),
      .lpm_wr_addr(lpm_wr_addr), .lpm_wr_req(lpm_wr_req), .lpm_wr_ip(lpm_wr_ip),
      .lpm_wr_mask(lpm_wr_mask), .lpm_wr_oq(lpm_wr_oq),
      .lpm_wr_next_hop_ip(lpm_wr_next_hop_ip), .lpm_wr_ack(lpm_wr_ack),
      .lpm_cnt_clr(lpm_cnt_clr), .lpm_hit_cnt(lpm_hit_cnt), .lpm_miss_cnt(lpm_miss_cnt));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Route semantics: scan from index 0, first valid entry whose masked bits agree wins.
   function automatic void ref_lookup(input logic [31:0] d, output logic h,
                                      output logic [NQ-1:0] oq, output logic [31:0] nh);
      h = 1'b0; oq = '0; nh = d;
      for (int i = 0; i < LD; i++) begin
         if (m_oq[i] != 0 && (d & m_mask[i]) == (m_ip[i] & m_mask[i])) begin
            h = 1'b1; oq = m_oq[i]; nh = (m_nh[i] != 0) ? m_nh[i] : d;
            return;
         end
      end
   endfunction

   task automatic set_lookup(input logic [31:0] ip);
      in_data = {ip[15:0], 32'h0, ip[31:16]};
      word_IP_SRC_DST = 1'b1;
      word_IP_DST_LO  = 1'b1;
   endtask

   task automatic idle_lookup();
      word_IP_SRC_DST = 1'b0;
      word_IP_DST_LO  = 1'b0;
      in_data = '0;
   endtask

   task automatic set_write(input int a, input logic [31:0] ip, input logic [31:0] mask,
                            input logic [NQ-1:0] oq, input logic [31:0] nh);
      lpm_wr_req = 1'b1; lpm_wr_addr = LB'(a);
      lpm_wr_ip = ip; lpm_wr_mask = mask; lpm_wr_oq = oq; lpm_wr_next_hop_ip = nh;
   endtask

   task automatic do_write(input int a, input logic [31:0] ip, input logic [31:0] mask,
                           input logic [NQ-1:0] oq, input logic [31:0] nh);
      set_write(a, ip, mask, oq, nh);
      tick();
      lpm_wr_req = 1'b0;
      m_ip[a] = ip; m_mask[a] = mask; m_oq[a] = oq; m_nh[a] = nh;
   endtask

   task automatic do_read(input int a);
      lpm_rd_req = 1'b1; lpm_rd_addr = LB'(a);
      tick();
      lpm_rd_req = 1'b0;
   endtask

   task automatic pulse_clr();
      lpm_cnt_clr = 1'b1; tick(); lpm_cnt_clr = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      for (int i = 0; i < LD; i++) begin m_ip[i] = 0; m_mask[i] = 0; m_oq[i] = 0; m_nh[i] = 0; end
      tick();
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (lpm_vld !== 1'b0 || lpm_hit !== 1'b0) begin bad++;
         $display("FAIL reset_vld_hit got=%b%b exp=00", lpm_vld, lpm_hit); end
      total++; if (next_hop_ip !== 32'h0 || lpm_output_port !== 8'h0) begin bad++;
         $display("FAIL reset_result got nh=%h port=%h exp 0", next_hop_ip, lpm_output_port); end
      total++; if (lpm_hit_cnt !== 4'h0 || lpm_miss_cnt !== 4'h0) begin bad++;
         $display("FAIL reset_cnt got hit=%h miss=%h exp 0", lpm_hit_cnt, lpm_miss_cnt); end
      total++; if (lpm_rd_ack !== 1'b0 || lpm_wr_ack !== 1'b0 || lpm_rd_ip !== 32'h0 || lpm_rd_oq !== 8'h0) begin bad++;
         $display("FAIL reset_rdwr got rack=%b wack=%b rip=%h roq=%h exp 0", lpm_rd_ack, lpm_wr_ack, lpm_rd_ip, lpm_rd_oq); end
   endtask

   task automatic test_miss();
      set_lookup(32'h0A000001); tick(); idle_lookup(); tick();
      total++; if (lpm_vld !== 1'b0) begin bad++; $display("FAIL miss_early_vld got=%b exp=0", lpm_vld); end
      tick();
      total++; if (lpm_vld !== 1'b1 || lpm_hit !== 1'b0 || lpm_output_port !== 8'h0 || next_hop_ip !== 32'h0A000001) begin bad++;
         $display("FAIL miss_result got vld=%b hit=%b port=%h nh=%h exp 1 0 00 0a000001", lpm_vld, lpm_hit, lpm_output_port, next_hop_ip); end
      tick();
      total++; if (lpm_vld !== 1'b0 || lpm_miss_cnt !== 4'd1 || lpm_hit_cnt !== 4'd0) begin bad++;
         $display("FAIL miss_cnt got vld=%b miss=%0d hit=%0d exp 0 1 0", lpm_vld, lpm_miss_cnt, lpm_hit_cnt); end
      total++; if (next_hop_ip !== 32'h0A000001) begin bad++; $display("FAIL miss_hold got nh=%h exp 0a000001", next_hop_ip); end
   endtask

   task automatic test_basic();
      do_write(0, 32'h0A010000, 32'hFFFF0000, 8'h04, 32'h0);
      total++; if (lpm_wr_ack !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", lpm_wr_ack); end
      do_write(1, 32'h00000000, 32'h00000000, 8'h01, 32'hC0A80001);
      tick();
      total++; if (lpm_wr_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_pulse got=%b exp=0", lpm_wr_ack); end
      do_read(1);
      total++; if (lpm_rd_ack !== 1'b1 || lpm_rd_oq !== 8'h01 || lpm_rd_next_hop_ip !== 32'hC0A80001 || lpm_rd_mask !== 32'h0) begin bad++;
         $display("FAIL rd_entry1 got ack=%b oq=%h nh=%h mask=%h exp 1 01 c0a80001 0", lpm_rd_ack, lpm_rd_oq, lpm_rd_next_hop_ip, lpm_rd_mask); end
      tick();
      total++; if (lpm_rd_ack !== 1'b0 || lpm_rd_oq !== 8'h01) begin bad++;
         $display("FAIL rd_hold got ack=%b oq=%h exp 0 01", lpm_rd_ack, lpm_rd_oq); end
      set_lookup(32'h0A010203); tick(); idle_lookup(); tick(); tick();
      total++; if (lpm_vld !== 1'b1 || lpm_hit !== 1'b1 || lpm_output_port !== 8'h04 || next_hop_ip !== 32'h0A010203) begin bad++;
         $display("FAIL hit_e0 got vld=%b hit=%b port=%h nh=%h exp 1 1 04 0a010203", lpm_vld, lpm_hit, lpm_output_port, next_hop_ip); end
      set_lookup(32'h0B000001); tick(); idle_lookup(); tick(); tick();
      total++; if (lpm_vld !== 1'b1 || lpm_hit !== 1'b1 || lpm_output_port !== 8'h01 || next_hop_ip !== 32'hC0A80001) begin bad++;
         $display("FAIL hit_default got vld=%b hit=%b port=%h nh=%h exp 1 1 01 c0a80001", lpm_vld, lpm_hit, lpm_output_port, next_hop_ip); end
      tick();
   endtask

   task automatic test_priority();
      do_write(1, 32'h0, 32'h0, 8'h00, 32'h0);
      do_write(3, 32'hAC100500, 32'hFFFFFF00, 8'h10, 32'h0);
      do_write(5, 32'hAC100000, 32'hFFFF0000, 8'h40, 32'h0);
      set_lookup(32'hAC100505); tick(); idle_lookup(); tick(); tick();
      total++; if (lpm_vld !== 1'b1 || lpm_output_port !== 8'h10) begin bad++;
         $display("FAIL prio_low got vld=%b port=%h exp 1 10", lpm_vld, lpm_output_port); end
      do_write(3, 32'hAC100500, 32'hFFFFFF00, 8'h00, 32'h0);
      set_lookup(32'hAC100505); tick(); idle_lookup(); tick(); tick();
      total++; if (lpm_vld !== 1'b1 || lpm_hit !== 1'b1 || lpm_output_port !== 8'h40) begin bad++;
         $display("FAIL prio_inval got vld=%b hit=%b port=%h exp 1 1 40", lpm_vld, lpm_hit, lpm_output_port); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [4];
      logic h; logic [NQ-1:0] oq; logic [31:0] nh;
      addrs[0] = 32'h0A010001; addrs[1] = 32'h08080808; addrs[2] = 32'h0A01FFFF; addrs[3] = 32'h09090909;
      pulse_clr();
      for (int c = 0; c < 8; c++) begin
         if (c >= 3 && c <= 6) begin
            ref_lookup(addrs[c-3], h, oq, nh);
            total++; if (lpm_vld !== 1'b1 || lpm_hit !== h || lpm_output_port !== oq || next_hop_ip !== nh) begin bad++;
               $display("FAIL b2b_%0d got vld=%b hit=%b port=%h nh=%h exp 1 %b %h %h", c-3, lpm_vld, lpm_hit, lpm_output_port, next_hop_ip, h, oq, nh); end
         end else if (c == 7) begin
            total++; if (lpm_vld !== 1'b0) begin bad++; $display("FAIL b2b_tail got vld=%b exp 0", lpm_vld); end
         end
         if (c < 4) set_lookup(addrs[c]); else idle_lookup();
         tick();
      end
      total++; if (lpm_hit_cnt !== 4'd2 || lpm_miss_cnt !== 4'd2) begin bad++;
         $display("FAIL b2b_cnt got hit=%0d miss=%0d exp 2 2", lpm_hit_cnt, lpm_miss_cnt); end
   endtask

   task automatic test_collision();
      set_lookup(32'h0A010203); tick(); idle_lookup();
      set_write(0, 32'h0A010000, 32'hFFFF0000, 8'h20, 32'h01020304); tick();
      lpm_wr_req = 1'b0; tick();
      total++; if (lpm_vld !== 1'b1 || lpm_output_port !== 8'h20 || next_hop_ip !== 32'h01020304) begin bad++;
         $display("FAIL coll_t1 got vld=%b port=%h nh=%h exp 1 20 01020304", lpm_vld, lpm_output_port, next_hop_ip); end
      do_write(0, 32'h0A010000, 32'hFFFF0000, 8'h04, 32'h0);
      set_lookup(32'h0A010203); tick(); idle_lookup(); tick();
      set_write(0, 32'h0A010000, 32'hFFFF0000, 8'h00, 32'h0); tick();
      lpm_wr_req = 1'b0;
      total++; if (lpm_vld !== 1'b1 || lpm_hit !== 1'b1 || lpm_output_port !== 8'h04 || next_hop_ip !== 32'h0A010203) begin bad++;
         $display("FAIL coll_t2 got vld=%b hit=%b port=%h nh=%h exp 1 1 04 0a010203", lpm_vld, lpm_hit, lpm_output_port, next_hop_ip); end
      do_write(0, 32'h0A010000, 32'hFFFF0000, 8'h04, 32'h0);
      lpm_rd_req = 1'b1; lpm_rd_addr = 3'd0;
      set_write(0, 32'h0A020000, 32'hFFFF0000, 8'h08, 32'h0); tick();
      lpm_rd_req = 1'b0; lpm_wr_req = 1'b0;
      m_ip[0] = 32'h0A020000; m_oq[0] = 8'h08;
      total++; if (lpm_rd_ack !== 1'b1 || lpm_wr_ack !== 1'b1 || lpm_rd_ip !== 32'h0A010000 || lpm_rd_oq !== 8'h04) begin bad++;
         $display("FAIL coll_rdwr got rack=%b wack=%b ip=%h oq=%h exp 1 1 0a010000 04", lpm_rd_ack, lpm_wr_ack, lpm_rd_ip, lpm_rd_oq); end
      do_read(0);
      total++; if (lpm_rd_ip !== 32'h0A020000 || lpm_rd_oq !== 8'h08) begin bad++;
         $display("FAIL coll_rdnew got ip=%h oq=%h exp 0a020000 08", lpm_rd_ip, lpm_rd_oq); end
      do_write(0, 32'h0A010000, 32'hFFFF0000, 8'h04, 32'h0);
      tick();
   endtask

   task automatic test_counters();
      pulse_clr();
      for (int i = 0; i < 20; i++) begin set_lookup(32'h08080808); tick(); end
      idle_lookup();
      for (int i = 0; i < 5; i++) tick();
      total++; if (lpm_miss_cnt !== 4'hF || lpm_hit_cnt !== 4'h0) begin bad++;
         $display("FAIL cnt_sat got miss=%h hit=%h exp f 0", lpm_miss_cnt, lpm_hit_cnt); end
      set_lookup(32'h0A010203); tick(); idle_lookup(); tick(); tick();
      total++; if (lpm_vld !== 1'b1) begin bad++; $display("FAIL cnt_clr_vld got=%b exp=1", lpm_vld); end
      lpm_cnt_clr = 1'b1; tick(); lpm_cnt_clr = 1'b0;
      total++; if (lpm_hit_cnt !== 4'h0 || lpm_miss_cnt !== 4'h0) begin bad++;
         $display("FAIL cnt_clr got hit=%h miss=%h exp 0 0", lpm_hit_cnt, lpm_miss_cnt); end
   endtask

   task automatic test_random();
      localparam int N = 300;
      logic [31:0] bases [4];
      logic        e_v [N+4];
      logic        e_h [N+4];
      logic [NQ-1:0] e_oq [N+4];
      logic [31:0] e_nh [N+4];
      int len; logic [31:0] m, d;
      bases[0] = 32'h0A000000; bases[1] = 32'hC0A80000; bases[2] = 32'hAC100000; bases[3] = 32'h64400000;
      for (int i = 0; i < LD; i++) begin
         len = $urandom_range(32, 0);
         m = (len == 0) ? 32'h0 : (32'hFFFFFFFF << (32 - len));
         do_write(i, bases[$urandom_range(3, 0)] | ($urandom & 32'h0000FFFF), m,
                  ($urandom_range(3, 0) == 0) ? 8'h00 : NQ'($urandom),
                  ($urandom_range(1, 0) == 0) ? 32'h0 : $urandom);
      end
      tick();
      for (int c = 0; c < N + 4; c++) begin
         if (c >= 3) begin
            total++; if (lpm_vld !== e_v[c-3]) begin bad++;
               $display("FAIL rnd_vld_c%0d got=%b exp=%b", c, lpm_vld, e_v[c-3]); end
            else if (e_v[c-3]) begin
               total++; if (lpm_hit !== e_h[c-3] || lpm_output_port !== e_oq[c-3] || next_hop_ip !== e_nh[c-3]) begin bad++;
                  $display("FAIL rnd_res_c%0d got hit=%b port=%h nh=%h exp %b %h %h", c, lpm_hit, lpm_output_port, next_hop_ip, e_h[c-3], e_oq[c-3], e_nh[c-3]); end
            end
         end
         e_v[c] = (c < N) && ($urandom_range(3, 0) != 0);
         e_h[c] = 1'b0; e_oq[c] = '0; e_nh[c] = '0;
         if (e_v[c]) begin
            d = m_ip[$urandom_range(LD-1, 0)] ^ ($urandom >> $urandom_range(31, 8));
            if ($urandom_range(7, 0) == 0) d = $urandom;
            ref_lookup(d, e_h[c], e_oq[c], e_nh[c]);
            set_lookup(d);
         end else idle_lookup();
         tick();
      end
      idle_lookup();
   endtask

   task automatic test_reset_mid();
      set_lookup(32'h0A010203); tick(); idle_lookup();
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++; if (lpm_vld !== 1'b0) begin bad++; $display("FAIL rst_mid_vld_%0d got=%b exp=0", i, lpm_vld); end
         tick();
      end
      do_read(0);
      total++; if (lpm_rd_ip !== 32'h0 || lpm_rd_mask !== 32'h0 || lpm_rd_oq !== 8'h0) begin bad++;
         $display("FAIL rst_tbl got ip=%h mask=%h oq=%h exp 0", lpm_rd_ip, lpm_rd_mask, lpm_rd_oq); end
   endtask

   initial begin
      reset = 1'b1; idle_lookup();
      lpm_rd_req = 0; lpm_rd_addr = '0; lpm_wr_req = 0; lpm_wr_addr = '0;
      lpm_wr_ip = 0; lpm_wr_mask = 0; lpm_wr_oq = 0; lpm_wr_next_hop_ip = 0; lpm_cnt_clr = 0;
      test_reset();
      test_miss();
      test_basic();
      test_priority();
      test_back_to_back();
      test_collision();
      test_counters();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
